// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scanning channel multiplexer.
package scan_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Dwell counter width; covers DWELL up to 255.
  localparam int CNT_W = 8;

  // Channel index width: at least one bit even for tiny channel counts.
  function automatic int sw_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/next_ch_find.sv
// Circular search for the next unmasked channel strictly above cur.
// Landing on an index <= cur (including cur itself) reports a wrap.
module next_ch_find
  import scan_mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int SW   = sw_width(N_CH)
) (
  input  logic [SW-1:0]   cur,
  input  logic [N_CH-1:0] mask,
  output logic [SW-1:0]   nxt,
  output logic            wrapped,
  output logic            none
);

  localparam int NP = 2**SW;

  logic [NP-1:0] mask_x;
  logic          found;

  // Pad the mask to the full index space so any SW-bit index is legal.
  assign mask_x = NP'(mask);
  assign none   = ~|mask;

  // First set bit at offsets 1..N_CH from cur, modulo N_CH.
  always_comb begin
    nxt     = cur;
    wrapped = 1'b0;
    found   = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!found && mask_x[SW'((int'(cur) + i) % N_CH)]) begin
        found   = 1'b1;
        nxt     = SW'((int'(cur) + i) % N_CH);
        wrapped = ((int'(cur) + i) >= N_CH);
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered channel multiplexer with direct select and masked auto-scan.
// In scan mode each unmasked channel is held for DWELL enabled cycles.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int W     = 4,
  parameter  int DWELL = 4,
  localparam int SW    = sw_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [N_CH-1:0]   mask,
  input  logic [N_CH*W-1:0] din,
  output logic [W-1:0]      y,
  output logic [SW-1:0]     ch,
  output logic              valid,
  output logic              wrap
);

  localparam int               NP       = 2**SW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [W-1:0]     chan [NP];
  logic [NP-1:0]    mask_x;
  logic             sel_ok;
  logic             cur_on;
  logic [SW-1:0]    nxt;
  logic             wrapped;
  logic             none;

  logic [W-1:0]     y_q, y_d;
  logic [SW-1:0]    ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Unpack din into a power-of-two table; unused slots read as zero.
  for (genvar k = 0; k < NP; k++) begin : g_chan
    if (k < N_CH) begin : g_real
      assign chan[k] = din[k*W +: W];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  assign mask_x = NP'(mask);
  // sel is wide enough to address past the last channel when N_CH is not a power of two.
  assign sel_ok = (int'(sel) < N_CH);
  assign cur_on = mask_x[ch_q];

  next_ch_find #(
    .N_CH (N_CH),
    .SW   (SW)
  ) u_find (
    .cur     (ch_q),
    .mask    (mask),
    .nxt     (nxt),
    .wrapped (wrapped),
    .none    (none)
  );

  // Next-state selection; valid and wrap default low so idle cycles drop them.
  always_comb begin
    y_d     = y_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (en) begin
      if (mode_e'(mode) == MODE_DIRECT) begin
        cnt_d = '0;
        if (sel_ok) begin
          ch_d    = sel;
          y_d     = chan[sel];
          valid_d = 1'b1;
        end else begin
          y_d = '0;
        end
      end else if (none) begin
        cnt_d = '0;
      end else if (!cur_on || (cnt_q == CNT_LAST)) begin
        // A masked live channel is left immediately so its data never shows as valid.
        cnt_d   = '0;
        ch_d    = nxt;
        y_d     = chan[nxt];
        valid_d = 1'b1;
        wrap_d  = wrapped;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        y_d     = chan[ch_q];
        valid_d = 1'b1;
      end
    end
  end

  // Output and dwell registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y     = y_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

  localparam logic [31:0] DIN_A = 32'h3CA9_56E1;
  localparam logic [59:0] DIN_B = {12'h4A5, 12'h3A5, 12'h2A5, 12'h1A5, 12'h0A5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, mode_a;
  logic [2:0]  sel_a;
  logic [7:0]  mask_a;
  logic [31:0] din_a;
  logic [3:0]  y_a;
  logic [2:0]  ch_a;
  logic        valid_a, wrap_a;

  logic        rst_b, en_b, mode_b;
  logic [2:0]  sel_b;
  logic [4:0]  mask_b;
  logic [59:0] din_b;
  logic [11:0] y_b;
  logic [2:0]  ch_b;
  logic        valid_b, wrap_b;

  scan_mux #(.N_CH(8), .W(4), .DWELL(4)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .sel(sel_a),
    .mask(mask_a), .din(din_a), .y(y_a), .ch(ch_a), .valid(valid_a), .wrap(wrap_a)
  );

  scan_mux #(.N_CH(5), .W(12), .DWELL(1)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .sel(sel_b),
    .mask(mask_b), .din(din_b), .y(y_b), .ch(ch_b), .valid(valid_b), .wrap(wrap_b)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of instance A: channel k data, next enabled channel by search.
  logic [3:0] m_y;
  int         m_ch, m_cnt;
  bit         m_valid, m_wrap;

  function automatic int chan_a(input int k);
    return int'((din_a >> (4 * k)) & 32'hF);
  endfunction

  function automatic int next_on(input int cur, input logic [7:0] m);
    for (int i = 1; i <= 8; i++)
      if (m[3'((cur + i) % 8)]) return (cur + i) % 8;
    return cur;
  endfunction

  always @(posedge clk) begin
    if (rst_a) begin
      m_y = '0; m_ch = 0; m_cnt = 0; m_valid = 0; m_wrap = 0;
    end else if (!en_a) begin
      m_valid = 0; m_wrap = 0;
    end else if (mode_a == 1'b0) begin
      m_cnt = 0; m_wrap = 0;
      if (int'(sel_a) < 8) begin
        m_ch = int'(sel_a); m_y = 4'(chan_a(m_ch)); m_valid = 1;
      end else begin
        m_y = '0; m_valid = 0;
      end
    end else if (mask_a == 8'h00) begin
      m_valid = 0; m_wrap = 0; m_cnt = 0;
    end else if (!mask_a[3'(m_ch)] || m_cnt == 3) begin
      int n;
      n = next_on(m_ch, mask_a);
      m_wrap = (n <= m_ch);
      m_ch = n; m_y = 4'(chan_a(n)); m_valid = 1; m_cnt = 0;
    end else begin
      m_cnt++; m_y = 4'(chan_a(m_ch)); m_valid = 1; m_wrap = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_y", y_a, m_y);
      check("mdl_ch", ch_a, m_ch);
      check("mdl_valid", valid_a, m_valid);
      check("mdl_wrap", wrap_a, m_wrap);
      check("mdl_cnt", u_a.cnt_q, m_cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int exp_full [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
  int exp_sp   [5] = '{2, 7, 2, 7, 2};
  int exp_spw  [5] = '{0, 0, 1, 0, 1};
  int exp_bch  [6] = '{3, 4, 0, 1, 2, 3};
  int exp_bwr  [6] = '{0, 0, 1, 0, 0, 0};
  logic [11:0] exp_by [6] = '{12'h3A5, 12'h4A5, 12'h0A5, 12'h1A5, 12'h2A5, 12'h3A5};

  initial begin
    int prev, nchg, last_c, g;
    rst_a = 1; en_a = 0; mode_a = 0; sel_a = 0; mask_a = 8'h00; din_a = DIN_A;
    rst_b = 1; en_b = 0; mode_b = 0; sel_b = 0; mask_b = 5'h00; din_b = DIN_B;

    step();
    chk_en = 1'b1;
    check("rst_y", y_a, 0);
    check("rst_ch", ch_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_wrap", wrap_a, 0);
    step();

    // Direct select
    rst_a = 0; en_a = 1; mode_a = 0; sel_a = 3'd5;
    step();
    check("dir5_y", y_a, 4'hA);
    check("dir5_ch", ch_a, 5);
    check("dir5_valid", valid_a, 1);
    sel_a = 3'd7;
    step();
    check("dir7_y", y_a, 4'h3);
    check("dir7_ch", ch_a, 7);
    sel_a = 3'd0;
    step();
    check("dir0_y", y_a, 4'h1);

    // Full scan
    mode_a = 1; mask_a = 8'hFF;
    prev = int'(ch_a); nchg = 0; last_c = 0;
    for (int c = 0; c < 34; c++) begin
      step();
      if (int'(ch_a) != prev) begin
        if (nchg < 8) begin
          check("full_ch", ch_a, exp_full[nchg]);
          check("full_wrap", wrap_a, exp_full[nchg] == 0);
          if (nchg > 0) check("full_dwell", c - last_c, 4);
        end
        nchg++; last_c = c; prev = int'(ch_a);
      end
    end
    check("full_nchg", nchg, 8);

    // Sparse scan
    mask_a = 8'b1000_0100;
    prev = int'(ch_a); nchg = 0; last_c = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (int'(ch_a) != prev) begin
        if (nchg < 5) begin
          check("sp_ch", ch_a, exp_sp[nchg]);
          check("sp_wrap", wrap_a, exp_spw[nchg]);
          if (nchg > 0) check("sp_dwell", c - last_c, 4);
        end
        nchg++; last_c = c; prev = int'(ch_a);
      end
    end
    check("sp_nchg", nchg, 5);

    // All masked
    mask_a = 8'h00;
    step();
    check("m0_valid", valid_a, 0);
    check("m0_ch", ch_a, 2);
    check("m0_wrap", wrap_a, 0);
    step();
    step();
    check("m0_ch_hold", ch_a, 2);
    check("m0_y_hold", y_a, 4'h6);
    check("m0_cnt", u_a.cnt_q, 0);

    // Masking the live channel
    mode_a = 0; sel_a = 3'd3;
    step();
    check("d3_ch", ch_a, 3);
    mode_a = 1; mask_a = 8'hFF;
    step();
    check("s3_ch", ch_a, 3);
    check("s3_cnt", u_a.cnt_q, 1);
    mask_a = 8'hF7;
    step();
    check("lm_ch", ch_a, 4);
    check("lm_cnt", u_a.cnt_q, 0);
    check("lm_y", y_a, 4'h9);
    check("lm_valid", valid_a, 1);

    // Freeze mid-dwell
    mask_a = 8'hFF;
    step();
    en_a = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("frz_valid", valid_a, 0);
      check("frz_ch", ch_a, 4);
      check("frz_cnt", u_a.cnt_q, 1);
    end
    en_a = 1;
    step();
    check("thaw_cnt", u_a.cnt_q, 2);
    step();
    step();
    check("thaw_ch", ch_a, 5);
    check("thaw_y", y_a, 4'hA);

    // Reset mid-scan
    g = 0;
    while (ch_a != 3'd6 && g < 20) begin
      step();
      g++;
    end
    check("reach_ch6", ch_a, 6);
    rst_a = 1;
    step();
    check("mrst_y", y_a, 0);
    check("mrst_ch", ch_a, 0);
    check("mrst_valid", valid_a, 0);
    check("mrst_cnt", u_a.cnt_q, 0);
    rst_a = 0;
    step();
    check("rel_ch", ch_a, 0);
    check("rel_y", y_a, 4'h1);
    check("rel_valid", valid_a, 1);
    rst_a = 1; mask_a = 8'b0000_0110;
    step();
    rst_a = 0;
    step();
    check("rel1_ch", ch_a, 1);
    check("rel1_y", y_a, 4'hE);
    check("rel1_wrap", wrap_a, 0);
    check("rel1_cnt", u_a.cnt_q, 0);

    // Instance B: N_CH=5, W=12, DWELL=1
    step();
    check("b_rst_y", y_b, 0);
    check("b_rst_ch", ch_b, 0);
    check("b_rst_valid", valid_b, 0);
    rst_b = 0; en_b = 1; mode_b = 0; sel_b = 3'd2;
    step();
    check("b_dir_ch", ch_b, 2);
    check("b_dir_y", y_b, 12'h2A5);
    check("b_dir_valid", valid_b, 1);
    sel_b = 3'd6;
    step();
    check("b_oor_y", y_b, 0);
    check("b_oor_valid", valid_b, 0);
    check("b_oor_ch", ch_b, 2);
    mode_b = 1; mask_b = 5'h1F;
    for (int i = 0; i < 6; i++) begin
      step();
      check("b_scan_ch", ch_b, exp_bch[i]);
      check("b_scan_wrap", wrap_b, exp_bwr[i]);
      check("b_scan_y", y_b, exp_by[i]);
      check("b_scan_valid", valid_b, 1);
    end

    chk_en = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 The block SHALL have parameter N_CH, default 8, giving the number of input channels (2..16).
REQ-002 The block SHALL have parameter W, default 4, giving the channel data width in bits.
REQ-003 The block SHALL have parameter DWELL, default 4, giving the cycles spent on each channel in scan mode (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit: advance/update enable.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = direct select, 1 = auto-scan.
REQ-008 The block SHALL have port sel, input, SW = max(1, clog2(N_CH)) bits: channel index used in direct mode.
REQ-009 The block SHALL have port mask, input, N_CH bits: per-channel scan enable, where 1 means the channel is included.
REQ-010 The block SHALL have port din, input, N_CH*W bits: flattened channel data, with channel k at bits [k*W +: W].
REQ-011 The block SHALL have port y, output, W bits: registered selected data.
REQ-012 The block SHALL have port ch, output, SW bits: index of the channel currently driving y.
REQ-013 The block SHALL have port valid, output, 1 bit: y holds valid channel data.
REQ-014 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when the scan wraps from the highest to a lower channel.

Function
REQ-015 All outputs SHALL be registered, with latency of 1 cycle from din/sel to y.
REQ-016 With en=1 and mode=0, next cycle the block SHALL set ch=sel, y=din[sel], valid=1, wrap=0; mask is ignored.
REQ-017 In direct mode with sel >= N_CH, the block SHALL set y=0 and valid=0, and hold ch.
REQ-018 Scan mode SHALL use an internal dwell counter cnt, 0..DWELL-1, incremented on each en=1 cycle.
REQ-019 In scan mode with cnt < DWELL-1, the block SHALL hold ch, refresh y=din[ch] every cycle, and set valid=1.
REQ-020 In scan mode with cnt = DWELL-1, the block SHALL clear cnt and advance ch to the next index above ch with mask=1, searching circularly; y SHALL take the new channel's data in that same update.
REQ-021 When the advance in REQ-020 selects an index lower than or equal to the old ch, the block SHALL pulse wrap=1 for one cycle.
REQ-022 When exactly one channel is unmasked, the advance SHALL return the same ch and pulse wrap at each dwell expiry.
REQ-023 When mask is all zero in scan mode, the block SHALL set valid=0, hold ch and y, hold cnt at 0, and keep wrap=0.
REQ-024 When the current ch becomes masked during scan, the block SHALL advance on the next en cycle regardless of cnt, clear cnt, and never present masked data with valid=1.
REQ-025 On a direct-to-scan transition, the block SHALL start scanning at the current ch if it is unmasked (otherwise apply REQ-024), with cnt=0.
REQ-026 On a scan-to-direct transition, REQ-016 SHALL apply on the first direct cycle, and cnt SHALL be cleared.
REQ-027 With en=0, all registers SHALL hold, and valid and wrap SHALL be forced to 0 in the following cycle.
REQ-028 The block SHALL read din on the clock edge in use; the data captured is the data present at that edge.

Reset
REQ-029 When rst=1 on a clock edge, the block SHALL set y=0, ch=0, valid=0, wrap=0, cnt=0; rst SHALL take priority over en and mode.
REQ-030 Reset asserted mid-scan SHALL abandon the dwell; after release, scan SHALL start at channel 0 if unmasked, otherwise at the next unmasked channel, with cnt=0.

Structure
REQ-031 A shared package scan_mux_pkg SHALL hold the mode encodings MODE_DIRECT=0 and MODE_SCAN=1, and the SW width function.
REQ-032 The next-unmasked-channel search SHALL be a combinational sub-module next_ch_find (inputs: cur, mask; outputs: nxt, wrapped, none).
REQ-033 No other sub-modules SHALL be used; the dwell counter and output registers SHALL reside in scan_mux.

Verification
REQ-034 Direct mode: with default parameters, rst then en=1, mode=0, sel=5, din ch5=4'hA -> y=A, ch=5, valid=1 one cycle later; sel=7 with ch7=3 -> y=3.
REQ-035 Scan full: mask=8'hFF, DWELL=4 -> ch steps 0,1,...,7,0 every 4 cycles; wrap=1 exactly on the 7->0 step.
REQ-036 Scan sparse: mask=8'b1000_0100 -> ch alternates 2,7,2 with a 4-cycle dwell; wrap on 7->2; mask=0 -> valid=0 and ch frozen.
REQ-037 Masking live channel: during scan at ch=3, cycle 1 of the dwell, clear mask[3] -> next cycle ch=4 and cnt=0, with no valid cycle on ch3 data.
REQ-038 Freeze and reset: en=0 for 5 cycles mid-dwell -> ch and cnt unchanged and valid=0; rst at ch=6 -> all outputs 0, and scan restarts at ch=0.
REQ-039 Parameter sweep: N_CH=5, W=12, DWELL=1 -> ch cycles 0..4 every cycle; direct sel=6 -> valid=0 and y=0.
